// File: rtl/full_adder_reg_pkg.sv
// Purpose : shared constants for the registered adder slice.
// Latency : n/a (package only).
// Backpressure: n/a.
//
// Contents: default operand width used by the interface and the top.
package full_adder_reg_pkg;

    // Default operand width; WIDTH = 1 gives the classic full adder.
    localparam int FA_DEFAULT_WIDTH = 1;

endpackage : full_adder_reg_pkg

// File: rtl/full_adder_reg_if.sv
// Purpose : operand/result bundle for full_adder_reg.
// Latency : n/a (wires only).
// Backpressure: none; there is no ready signal, the adder accepts every valid.
//
// Signals: in_valid, a, b, cin (operand side); sum, cout, ovf, out_valid (result side).
// Modports: master drives operands and observes results; slave is the adder.
interface full_adder_reg_if
    import full_adder_reg_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             out_valid;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        input  sum,
        input  cout,
        input  ovf,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        output sum,
        output cout,
        output ovf,
        output out_valid
    );

endinterface : full_adder_reg_if

// File: rtl/full_adder_cell.sv
// Purpose : 1-bit full adder cell, one link of the ripple chain.
// Latency : combinational.
// Backpressure: none.
//
// Ports: a, b, cin in; sum = a^b^cin, cout = majority(a, b, cin) out.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_cell

// File: rtl/full_adder_reg.sv
// Purpose : registered WIDTH-bit adder (a + b + cin) with carry-out and signed overflow.
// Latency : 1 cycle from in_valid to out_valid/result.
// Backpressure: none; one add per cycle, back-to-back valids accepted.
//
// Ports: clk, rst_n (async, active-low) plain; bus (slave modport) carries
//        in_valid/a/b/cin in and sum/cout/ovf/out_valid out.
//        The interface instance must be built with the same WIDTH as this module.
module full_adder_reg
    import full_adder_reg_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    full_adder_reg_if.slave     bus
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic             ovf_d;

    assign c[0] = bus.cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            full_adder_cell u_cell (
                .a    (bus.a[i]),
                .b    (bus.b[i]),
                .cin  (c[i]),
                .sum  (s[i]),
                .cout (c[i+1])
            );
        end
    endgenerate

    // Signed overflow: carry into MSB differs from carry out of MSB.
    // For WIDTH = 1 the carry into the MSB is cin itself.
    assign ovf_d = c[WIDTH] ^ c[WIDTH-1];

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             out_valid_q;

    // Result registers only move on a valid cycle, so garbage or X on the
    // operands while in_valid is low never reaches the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (bus.in_valid) begin
            sum_q  <= s;
            cout_q <= c[WIDTH];
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;

endmodule : full_adder_reg

// File: tb/tb_full_adder_reg.sv
// Purpose : directed self-checking bench for full_adder_reg at WIDTH 1 and 8.
// Latency : checks results one edge after operands are applied.
// Backpressure: n/a.
module tb_full_adder_reg;

    logic clk;
    logic rst_n;

    int pass_cnt;
    int total_cnt;

    full_adder_reg_if #(.WIDTH(1)) bus1 ();
    full_adder_reg_if #(.WIDTH(8)) bus8 ();

    full_adder_reg #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    full_adder_reg #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one 8-bit operand set on the falling edge, then step to 1 time
    // unit after the capturing rising edge.
    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        @(negedge clk);
        bus8.in_valid = 1'b1;
        bus8.a        = a;
        bus8.b        = b;
        bus8.cin      = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus1.in_valid = 1'b1;
        bus1.a        = 1'b1;
        bus1.b        = 1'b1;
        bus1.cin      = 1'b1;
        bus8.in_valid = 1'b1;
        bus8.a        = 8'hFF;
        bus8.b        = 8'hFF;
        bus8.cin      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum} !== 11'h000)
            $display("FAIL reset_w8: got ov/ovf/cout/sum=%b required 0", {bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum});
        else pass_cnt++;
        total_cnt++;
        if ({bus1.out_valid, bus1.ovf, bus1.cout, bus1.sum} !== 4'b0000)
            $display("FAIL reset_w1: got ov/ovf/cout/sum=%b required 0000", {bus1.out_valid, bus1.ovf, bus1.cout, bus1.sum});
        else pass_cnt++;
        @(negedge clk);
        rst_n         = 1'b1;
        bus1.in_valid = 1'b0;
        bus8.in_valid = 1'b0;
    endtask

    task automatic test_truth_table;
        logic [1:0] exp_tab [8];
        logic [2:0] v;
        exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            bus1.in_valid = 1'b1;
            bus1.a        = v[2];
            bus1.b        = v[1];
            bus1.cin      = v[0];
            @(posedge clk);
            #1;
            total_cnt++;
            if ({bus1.cout, bus1.sum} !== exp_tab[i])
                $display("FAIL tt_%0d: got {cout,sum}=%b required %b", i, {bus1.cout, bus1.sum}, exp_tab[i]);
            else pass_cnt++;
            total_cnt++;
            if (bus1.ovf !== (exp_tab[i][1] ^ v[0]))
                $display("FAIL tt_ovf_%0d: got %b required %b", i, bus1.ovf, exp_tab[i][1] ^ v[0]);
            else pass_cnt++;
            total_cnt++;
            if (bus1.out_valid !== 1'b1)
                $display("FAIL tt_valid_%0d: got %b required 1", i, bus1.out_valid);
            else pass_cnt++;
        end
        @(negedge clk);
        bus1.in_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        drive8(8'hFF, 8'h01, 1'b0);
        total_cnt++;
        if ({bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum} !== {1'b1, 1'b0, 1'b1, 8'h00})
            $display("FAIL w8_ff_01: got ov/ovf/cout/sum=%b required 1_0_1_00000000", {bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum});
        else pass_cnt++;
        drive8(8'h7F, 8'h00, 1'b1);
        total_cnt++;
        if ({bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum} !== {1'b1, 1'b1, 1'b0, 8'h80})
            $display("FAIL w8_7f_cin: got ov/ovf/cout/sum=%b required 1_1_0_10000000", {bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum});
        else pass_cnt++;
        drive8(8'h80, 8'h80, 1'b0);
        total_cnt++;
        if ({bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum} !== {1'b1, 1'b1, 1'b1, 8'h00})
            $display("FAIL w8_80_80: got ov/ovf/cout/sum=%b required 1_1_1_00000000", {bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum});
        else pass_cnt++;
    endtask

    task automatic test_hold;
        drive8(8'h12, 8'h34, 1'b0);
        total_cnt++;
        if ({bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum} !== {1'b1, 1'b0, 1'b0, 8'h46})
            $display("FAIL hold_load: got ov/ovf/cout/sum=%b required 1_0_0_01000110", {bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum});
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus8.in_valid = 1'b0;
            if (i[0]) begin
                bus8.a   = 8'(($urandom_range(0, 255)));
                bus8.b   = 8'(($urandom_range(0, 255)));
                bus8.cin = 1'b1;
            end else begin
                bus8.a   = 'x;
                bus8.b   = 'x;
                bus8.cin = 1'bx;
            end
            @(posedge clk);
            #1;
            total_cnt++;
            if ({bus8.ovf, bus8.cout, bus8.sum} !== {1'b0, 1'b0, 8'h46})
                $display("FAIL hold_%0d: got ovf/cout/sum=%b required 0_0_01000110", i, {bus8.ovf, bus8.cout, bus8.sum});
            else pass_cnt++;
            total_cnt++;
            if (bus8.out_valid !== 1'b0)
                $display("FAIL hold_valid_%0d: got %b required 0", i, bus8.out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset;
        drive8(8'h55, 8'h55, 1'b0);
        total_cnt++;
        if ({bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum} !== {1'b1, 1'b1, 1'b0, 8'hAA})
            $display("FAIL areset_pre: got ov/ovf/cout/sum=%b required 1_1_0_10101010", {bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum});
        else pass_cnt++;
        // Put a new operand in flight, then pull reset between edges.
        #1;
        bus8.a   = 8'h10;
        bus8.b   = 8'h20;
        bus8.cin = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum} !== 11'h000)
            $display("FAIL areset_now: got ov/ovf/cout/sum=%b required 0", {bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum});
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum} !== 11'h000)
            $display("FAIL areset_held: got ov/ovf/cout/sum=%b required 0", {bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum});
        else pass_cnt++;
        @(negedge clk);
        rst_n         = 1'b1;
        bus8.in_valid = 1'b1;
        bus8.a        = 8'h01;
        bus8.b        = 8'h01;
        bus8.cin      = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum} !== {1'b1, 1'b0, 1'b0, 8'h03})
            $display("FAIL areset_first: got ov/ovf/cout/sum=%b required 1_0_0_00000011", {bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum});
        else pass_cnt++;
        @(negedge clk);
        bus8.in_valid = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_truth_table();
        test_back_to_back();
        test_hold();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_full_adder_reg
